// File: rtl/dekatron_seek_ctrl.sv
// -----------------------------------------------------------------------------
// dekatron_seek_ctrl
//
// Moves a dekatron counting tube to a requested digit. There are two ways to
// get there:
//   - seek: step the glow left or right with timed guide pulses. The controller
//     takes the shorter way round and checks the Out feedback after each step.
//   - set:  drive the one-hot In vector to force the glow straight onto the
//     target. The result is then checked on Out.
//
// Ports
//   hsClk       in   clock, rising-edge
//   Rst         in   synchronous active-high reset
//   Request     in   start an operation (sampled only in IDLE)
//   Mode        in   0 = seek by stepping, 1 = direct set via In
//   Target[3:0] in   target digit 0..9
//   Out[9:0]    in   one-hot tube position feedback, bit n = digit n
//   PulseRight  out  step up (toward MSB, 9 wraps to 0)
//   PulseLeft   out  step down (0 wraps to 9)
//   In[9:0]     out  one-hot forced-set vector, zero unless setting
//   Busy        out  high in every state except IDLE
//   Done        out  one-cycle pulse on successful completion
//   Error       out  one-cycle pulse on failed completion
//
// State table
//   state  | meaning
//   IDLE   | waiting for Request; validates inputs and plans the move
//   SET    | driving In = one-hot(Target) for SET_LEN cycles
//   PULSE  | selected guide pulse high for PULSE_LEN cycles
//   GAP    | both pulses and In low for GAP_LEN cycles, tube settles
//   CHECK  | one cycle: compare Out with the expected position
//   FINISH | one cycle: Done or Error asserted, then back to IDLE
// -----------------------------------------------------------------------------
module dekatron_seek_ctrl #(
    parameter int PULSE_LEN = 3,
    parameter int GAP_LEN   = 4,
    parameter int SET_LEN   = 3
) (
    input  logic       hsClk,
    input  logic       Rst,
    input  logic       Request,
    input  logic       Mode,
    input  logic [3:0] Target,
    input  logic [9:0] Out,
    output logic       PulseRight,
    output logic       PulseLeft,
    output logic [9:0] In,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam int MAX_PG  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int MAX_LEN = (MAX_PG > SET_LEN) ? MAX_PG : SET_LEN;
    localparam int CW      = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);

    localparam logic [CW-1:0] P_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] G_LOAD = CW'(GAP_LEN - 1);
    localparam logic [CW-1:0] S_LOAD = CW'(SET_LEN - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SET    = 3'd1,
        PULSE  = 3'd2,
        GAP    = 3'd3,
        CHECK  = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    steps_q, steps_d;
    logic          dir_q, dir_d;      // 1 = right (up), 0 = left (down)
    logic [3:0]    exp_q, exp_d;      // digit Out must show at the next CHECK
    logic [3:0]    tgt_q, tgt_d;
    logic          ok_q, ok_d;        // result reported in FINISH

    // Request-time decode of the feedback and the planned move
    logic          out_onehot;
    logic [3:0]    cur_idx;
    logic [3:0]    fwd;
    logic          go_right;
    logic [2:0]    step_cnt;

    function automatic logic [3:0] step_pos(input logic [3:0] pos, input logic right);
        logic [3:0] r;
        if (right) begin
            r = (pos == 4'd9) ? 4'd0 : pos + 4'd1;
        end else begin
            r = (pos == 4'd0) ? 4'd9 : pos - 4'd1;
        end
        return r;
    endfunction

    function automatic logic [9:0] one_hot(input logic [3:0] idx);
        return 10'd1 << idx;
    endfunction

    always_comb begin
        out_onehot = (Out != 10'd0) && ((Out & (Out - 10'd1)) == 10'd0);
        cur_idx    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (Out[i]) begin
                cur_idx = 4'(i);
            end
        end
        // Both operands are at most 9 here, so the 4-bit wrap cannot corrupt the result.
        if (Target >= cur_idx) begin
            fwd = Target - cur_idx;
        end else begin
            fwd = Target + 4'd10 - cur_idx;
        end
        go_right = (fwd <= 4'd5);
        step_cnt = go_right ? fwd[2:0] : 3'(4'd10 - fwd);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        steps_d = steps_q;
        dir_d   = dir_q;
        exp_d   = exp_q;
        tgt_d   = tgt_q;
        ok_d    = ok_q;

        case (state_q)
            IDLE: begin
                if (Request) begin
                    tgt_d = Target;
                    if (Target > 4'd9) begin
                        ok_d    = 1'b0;
                        state_d = FINISH;
                    end else if (Mode) begin
                        // A set overrides whatever is on Out, so validity is not checked.
                        exp_d   = Target;
                        steps_d = 3'd1;
                        cnt_d   = S_LOAD;
                        state_d = SET;
                    end else if (!out_onehot) begin
                        ok_d    = 1'b0;
                        state_d = FINISH;
                    end else if (fwd == 4'd0) begin
                        ok_d    = 1'b1;
                        state_d = FINISH;
                    end else begin
                        dir_d   = go_right;
                        steps_d = step_cnt;
                        exp_d   = step_pos(cur_idx, go_right);
                        cnt_d   = P_LOAD;
                        state_d = PULSE;
                    end
                end
            end

            SET: begin
                if (cnt_q == '0) begin
                    cnt_d   = G_LOAD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = G_LOAD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            GAP: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            CHECK: begin
                if (Out != one_hot(exp_q)) begin
                    ok_d    = 1'b0;
                    state_d = FINISH;
                end else if (steps_q == 3'd1) begin
                    ok_d    = 1'b1;
                    state_d = FINISH;
                end else begin
                    steps_d = steps_q - 3'd1;
                    exp_d   = step_pos(exp_q, dir_q);
                    cnt_d   = P_LOAD;
                    state_d = PULSE;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge hsClk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            steps_q <= 3'd0;
            dir_q   <= 1'b0;
            exp_q   <= 4'd0;
            tgt_q   <= 4'd0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
            exp_q   <= exp_d;
            tgt_q   <= tgt_d;
            ok_q    <= ok_d;
        end
    end

    // Outputs decode from registered state only. The two pulses share PULSE
    // but are split by dir_q, so they can never be high together.
    assign PulseRight = (state_q == PULSE) &&  dir_q;
    assign PulseLeft  = (state_q == PULSE) && !dir_q;
    assign In         = (state_q == SET) ? one_hot(tgt_q) : 10'd0;
    assign Busy       = (state_q != IDLE);
    assign Done       = (state_q == FINISH) &&  ok_q;
    assign Error      = (state_q == FINISH) && !ok_q;

endmodule

// File: tb/tb_dekatron_seek_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dekatron_seek_ctrl
//
// Directed bench for dekatron_seek_ctrl with default parameters (3/4/3).
// A small dekatron model rotates its position on each rising edge of a guide
// pulse and takes any non-zero In vector as the new position. It can be told
// to ignore one chosen pulse, which stands in for a tube that failed to step.
// -----------------------------------------------------------------------------
module tb_dekatron_seek_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       request;
    logic       mode;
    logic [3:0] target;
    logic [9:0] out_m;
    logic       pulse_right;
    logic       pulse_left;
    logic [9:0] in_v;
    logic       busy;
    logic       done;
    logic       error;

    int checks   = 0;
    int failures = 0;

    dekatron_seek_ctrl dut (
        .hsClk      (clk),
        .Rst        (rst),
        .Request    (request),
        .Mode       (mode),
        .Target     (target),
        .Out        (out_m),
        .PulseRight (pulse_right),
        .PulseLeft  (pulse_left),
        .In         (in_v),
        .Busy       (busy),
        .Done       (done),
        .Error      (error)
    );

    always #5 clk = ~clk;

    // ---------------- dekatron model ----------------
    logic       preset_req = 1'b0;
    logic [9:0] preset_val = 10'd0;
    int         ignore_n   = 0;   // 1-based guide pulse to ignore, 0 = none
    int         pulse_seen = 0;
    logic       pr_prev    = 1'b0;
    logic       pl_prev    = 1'b0;

    initial out_m = 10'd0;

    always @(posedge clk) begin
        if (preset_req) begin
            out_m      <= preset_val;
            pulse_seen <= 0;
        end else if (in_v != 10'd0) begin
            out_m <= in_v;
        end else if ((pulse_right && !pr_prev) || (pulse_left && !pl_prev)) begin
            pulse_seen <= pulse_seen + 1;
            if (pulse_seen + 1 != ignore_n) begin
                if (pulse_right) out_m <= {out_m[8:0], out_m[9]};
                else             out_m <= {out_m[0], out_m[9:1]};
            end
        end
        pr_prev <= pulse_right;
        pl_prev <= pulse_left;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic set_out(input logic [9:0] v);
        @(negedge clk);
        preset_val = v;
        preset_req = 1'b1;
        @(negedge clk);
        preset_req = 1'b0;
    endtask

    // Per-operation observations
    int n_bursts, bad_len, bad_gap, pr_hi, pl_hi, overlap;
    int done_cnt, err_cnt, finish_idx, busy_after, in_match, in_bad;

    // Issue one request, then record every cycle until Done/Error. Sample 0
    // is the first cycle after the request edge. Mode/Target are scrambled
    // after sampling to show they are latched.
    task automatic run_op(input logic m, input logic [3:0] t, input logic [9:0] in_exp);
        int  hi_run = 0;
        int  lo_run = 0;
        logic prev  = 1'b0;
        logic p;
        n_bursts = 0; bad_len = 0; bad_gap = 0; pr_hi = 0; pl_hi = 0; overlap = 0;
        done_cnt = 0; err_cnt = 0; finish_idx = -1; busy_after = -1;
        in_match = 0; in_bad = 0;
        @(negedge clk);
        request = 1'b1; mode = m; target = t;
        @(posedge clk); #1;
        request = 1'b0; mode = ~m; target = 4'hF;
        for (int i = 0; i < 80; i++) begin
            p = pulse_right | pulse_left;
            if (pulse_right) pr_hi++;
            if (pulse_left)  pl_hi++;
            if (pulse_right && pulse_left) overlap++;
            if (in_v == in_exp && in_exp != 10'd0) in_match++;
            else if (in_v != 10'd0) in_bad++;
            if (p && !prev) begin
                if (n_bursts > 0 && lo_run != 5) bad_gap++;
                n_bursts++;
                hi_run = 0;
            end
            if (!p && prev && hi_run != 3) bad_len++;
            if (p) hi_run++; else lo_run = (prev ? 1 : lo_run + 1);
            prev = p;
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (done || error) begin
                finish_idx = i;
                @(posedge clk); #1;
                busy_after = busy;
                if (done) done_cnt++;
                if (error) err_cnt++;
                break;
            end
            @(posedge clk); #1;
        end
        if (finish_idx < 0) check("op_timeout", 0, 1);
    endtask

    initial begin
        int cnt_de;
        rst = 1'b1; request = 1'b0; mode = 1'b0; target = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pr",    pulse_right, 0);
        check("rst_pl",    pulse_left,  0);
        check("rst_in",    in_v,        0);
        check("rst_busy",  busy,        0);
        check("rst_done",  done,        0);
        check("rst_error", error,       0);
        @(negedge clk); rst = 1'b0;

        // 2 -> 5: three right steps
        set_out(10'b0000000100);
        run_op(1'b0, 4'd5, 10'd0);
        check("s25_bursts", n_bursts, 3);
        check("s25_pr_hi",  pr_hi, 9);
        check("s25_pl_hi",  pl_hi, 0);
        check("s25_len",    bad_len, 0);
        check("s25_gap",    bad_gap, 0);
        check("s25_fin",    finish_idx, 24);
        check("s25_done",   done_cnt, 1);
        check("s25_err",    err_cnt, 0);
        check("s25_busy",   busy_after, 0);
        check("s25_out",    out_m, 10'b0000100000);

        // 1 -> 8: fwd 7, three left steps wrapping through 0 and 9
        set_out(10'b0000000010);
        run_op(1'b0, 4'd8, 10'd0);
        check("s18_bursts", n_bursts, 3);
        check("s18_pl_hi",  pl_hi, 9);
        check("s18_pr_hi",  pr_hi, 0);
        check("s18_fin",    finish_idx, 24);
        check("s18_done",   done_cnt, 1);
        check("s18_out",    out_m, 10'b0100000000);

        // 1 -> 6: fwd 5, tie goes right, five steps
        set_out(10'b0000000010);
        run_op(1'b0, 4'd6, 10'd0);
        check("s16_bursts", n_bursts, 5);
        check("s16_pl_hi",  pl_hi, 0);
        check("s16_gap",    bad_gap, 0);
        check("s16_fin",    finish_idx, 40);
        check("s16_done",   done_cnt, 1);
        check("s16_out",    out_m, 10'b0001000000);

        // 4 -> 4: already there
        set_out(10'b0000010000);
        run_op(1'b0, 4'd4, 10'd0);
        check("s44_fin",    finish_idx, 0);
        check("s44_done",   done_cnt, 1);
        check("s44_pulses", pr_hi + pl_hi, 0);

        // Target 12: invalid
        run_op(1'b0, 4'd12, 10'd0);
        check("t12_fin",    finish_idx, 0);
        check("t12_err",    err_cnt, 1);
        check("t12_done",   done_cnt, 0);
        check("t12_pulses", pr_hi + pl_hi + in_match + in_bad, 0);

        // Out all zero with seek: invalid feedback
        set_out(10'b0000000000);
        run_op(1'b0, 4'd3, 10'd0);
        check("oz_fin",     finish_idx, 0);
        check("oz_err",     err_cnt, 1);
        check("oz_pulses",  pr_hi + pl_hi, 0);

        // Tube ignores the second step of 3 -> 6
        set_out(10'b0000001000);
        ignore_n = 2;
        run_op(1'b0, 4'd6, 10'd0);
        ignore_n = 0;
        check("ign_bursts", n_bursts, 2);
        check("ign_fin",    finish_idx, 16);
        check("ign_err",    err_cnt, 1);
        check("ign_done",   done_cnt, 0);
        check("ign_busy",   busy_after, 0);
        check("ign_out",    out_m, 10'b0000010000);

        // Direct set to 7 from invalid Out = 0
        set_out(10'b0000000000);
        run_op(1'b1, 4'd7, 10'b0010000000);
        check("set_in_cyc", in_match, 3);
        check("set_in_bad", in_bad, 0);
        check("set_pulses", pr_hi + pl_hi, 0);
        check("set_fin",    finish_idx, 8);
        check("set_done",   done_cnt, 1);
        check("set_out",    out_m, 10'b0010000000);

        // Request held through FINISH restarts only from the following IDLE
        set_out(10'b0000010000);
        @(negedge clk);
        request = 1'b1; mode = 1'b0; target = 4'd4;
        @(posedge clk); #1;
        check("hold_done0", done, 1);
        @(posedge clk); #1;
        check("hold_idle",  busy, 0);
        @(posedge clk); #1;
        check("hold_done1", done, 1);
        request = 1'b0;
        @(posedge clk); #1;
        check("hold_end",   busy, 0);

        // Reset during the second PULSE of 2 -> 5
        set_out(10'b0000000100);
        @(negedge clk);
        request = 1'b1; mode = 1'b0; target = 4'd5;
        @(posedge clk); #1;
        request = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("rmid_pr", pulse_right, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rmid_outs", {pulse_right, pulse_left, in_v, busy, done, error}, 0);
        rst = 1'b0;
        cnt_de = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || error || busy) cnt_de++;
        end
        check("rmid_quiet", cnt_de, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
